uart_tx_scheduler: RTL

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_scheduler.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Two-requester round-robin scheduler in front of a UART transmitter.
//   One byte is granted at a time. The block pulses tx_start, waits for the
//   transmitter to report busy (bounded by ACK_TIMEOUT), and waits for it to
//   go idle again. It then holds off for GAP_CYCLES before the next grant.
//
// Parameters
//   GAP_CYCLES  : idle cycles between frames (0 skips the gap entirely)
//   ACK_TIMEOUT : cycles allowed in WAIT_BUSY before err_timeout (1-255)
//
// Ports
//   clk, rst               : clock, synchronous active-high reset
//   chN_valid / chN_data   : requester N has a byte pending (held while valid)
//   chN_ready              : byte from requester N accepted this cycle
//   tx_start               : one-cycle launch pulse to the transmitter
//   tx_data                : registered byte for the transmitter
//   tx_busy                : transmitter is sending a frame
//   grant_id               : channel owning the current frame
//   active                 : scheduler is in any state other than IDLE
//   err_timeout            : one-cycle pulse when tx_busy never arrived
module uart_tx_scheduler #(
  parameter int GAP_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ch0_valid,
  input  logic [7:0] ch0_data,
  output logic       ch0_ready,
  input  logic       ch1_valid,
  input  logic [7:0] ch1_data,
  output logic       ch1_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       grant_id,
  output logic       active,
  output logic       err_timeout
);

  localparam logic [7:0]  TO_LAST  = 8'(ACK_TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  // Where a finished (or timed-out) frame goes; a zero gap returns straight to IDLE.
  localparam state_t AFTER_FRAME = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

  state_t      state_reg,   state_next;
  logic        ptr_reg,     ptr_next;
  logic [7:0]  tx_data_reg, tx_data_next;
  logic        grant_reg,   grant_next;
  logic [7:0]  to_cnt_reg,  to_cnt_next;
  logic [15:0] gap_cnt_reg, gap_cnt_next;
  logic        err_next;

  logic [1:0] valid_vec;
  logic [1:0] ready_vec;
  logic [7:0] data_arr [2];
  logic       sel;
  logic       in_idle;

  assign valid_vec   = {ch1_valid, ch0_valid};
  assign data_arr[0] = ch0_data;
  assign data_arr[1] = ch1_data;
  assign in_idle     = (state_reg == S_IDLE) && !rst;

  // Pointer breaks ties only; a lone requester wins regardless of it.
  always_comb begin
    sel = ptr_reg;
    if (!(valid_vec[0] && valid_vec[1])) begin
      sel = valid_vec[1];
    end
  end

  // Ready is one-hot by construction: only the selected channel can see it.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      assign ready_vec[gi] = in_idle && valid_vec[gi] && (sel == 1'(gi));
    end
  endgenerate

  assign ch0_ready = ready_vec[0];
  assign ch1_ready = ready_vec[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      ptr_reg     <= 1'b0;
      tx_data_reg <= 8'h00;
      grant_reg   <= 1'b0;
      to_cnt_reg  <= 8'd0;
      gap_cnt_reg <= 16'd0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      tx_data_reg <= tx_data_next;
      grant_reg   <= grant_next;
      to_cnt_reg  <= to_cnt_next;
      gap_cnt_reg <= gap_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    tx_data_next = tx_data_reg;
    grant_next   = grant_reg;
    to_cnt_next  = to_cnt_reg;
    gap_cnt_next = gap_cnt_reg;
    err_next     = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (|valid_vec) begin
          tx_data_next = data_arr[sel];
          grant_next   = sel;
          ptr_next     = ~sel;
          state_next   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        to_cnt_next = 8'd0;
        state_next  = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // A late acknowledge on the final allowed cycle still counts.
        if (tx_busy) begin
          state_next = S_WAIT_DONE;
        end else if (to_cnt_reg == TO_LAST) begin
          err_next     = 1'b1;
          gap_cnt_next = 16'd0;
          state_next   = AFTER_FRAME;
        end else begin
          to_cnt_next = to_cnt_reg + 8'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          gap_cnt_next = 16'd0;
          state_next   = AFTER_FRAME;
        end
      end
      S_GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          state_next = S_IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + 16'd1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign tx_start    = (state_reg == S_LAUNCH) && !rst;
  assign active      = (state_reg != S_IDLE) && !rst;
  assign err_timeout = err_next && !rst;
  assign tx_data     = tx_data_reg;
  assign grant_id    = grant_reg;

endmodule
